// File: rtl/serial_tx.sv
// serial_tx -- parallel-to-serial frame transmitter.
//
// Accepts one WIDTH-bit word through a valid/ready handshake and shifts it out
// on sdo as a frame:
//   start bit (0), WIDTH data bits LSB first, optional even parity bit, stop bit (1).
// Every bit is held for CLKS_PER_BIT clock cycles.
//
// Optional feature: define the macro PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit. When it is undefined, no parity
// state or parity logic is built.
//
// Parameters:
//   WIDTH        data bits per frame (1..32)
//   CLKS_PER_BIT clock cycles per serial bit (1..65535)
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   in_valid  in_data holds a word to send
//   in_data   parallel word, captured on handshake
//   in_ready  block accepts a word this cycle (IDLE only)
//   sdo       serial line, idle high
//   busy      a frame is in progress
//   done      one-cycle pulse in the IDLE cycle after the stop bit
//   fsm_state current FSM state encoding, for observation
//
// Handshake: a word transfers on a rising clk edge where in_valid and in_ready
// are both 1. in_ready does not depend on in_valid. The producer holds
// in_data stable while in_valid is high and in_ready is low. Inputs are
// ignored whenever in_ready is 0.
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sdo,
    output logic             busy,
    output logic             done,
    output logic [2:0]       fsm_state
);

    // Counters are sized for the largest count they must reach. A width of
    // at least one bit keeps CLKS_PER_BIT=1 and WIDTH=1 legal.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [BIT_W-1:0] bit_idx;
    logic [WIDTH-1:0] shift_q;
    logic             armed;
    logic             done_q;
    logic             bit_end;
    logic             handshake;
`ifdef PARITY_EN
    logic             par_q;
`endif

    assign bit_end   = (cnt == CNT_LAST);
    assign handshake = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (handshake) state_next = S_START;
            S_START: if (bit_end)   state_next = S_DATA;
            S_DATA: begin
                if (bit_end && (bit_idx == BIT_LAST)) begin
`ifdef PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef PARITY_EN
            S_PARITY: if (bit_end) state_next = S_STOP;
`endif
            S_STOP:  if (bit_end)   state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    // Outputs. sdo comes straight from the state, so an asynchronous reset
    // returns the line to idle-high without waiting for a clock edge.
    always_comb begin
        sdo = 1'b1;
        case (state)
            S_START:  sdo = 1'b0;
            S_DATA:   sdo = shift_q[0];
`ifdef PARITY_EN
            S_PARITY: sdo = par_q;
`endif
            default:  sdo = 1'b1;
        endcase
        busy      = (state != S_IDLE);
        in_ready  = (state == S_IDLE) && armed;
        done      = done_q;
        fsm_state = state;
    end

    // Datapath: bit-period counter, data bit index, shift register, done flag.
    // armed stays low during reset. It holds in_ready low until the first
    // rising edge after rst is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            armed   <= 1'b0;
            done_q  <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            armed  <= 1'b1;
            done_q <= (state == S_STOP) && bit_end;
            if (state == S_IDLE) begin
                if (handshake) begin
                    shift_q <= in_data;
                    cnt     <= '0;
                    bit_idx <= '0;
`ifdef PARITY_EN
                    par_q   <= ^in_data;
`endif
                end
            end else begin
                if (bit_end) cnt <= '0;
                else         cnt <= cnt + 1'b1;
                if ((state == S_DATA) && bit_end) begin
                    shift_q <= shift_q >> 1;
                    if (bit_idx == BIT_LAST) bit_idx <= '0;
                    else                     bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end

endmodule
